univ_shift_reg: RTL

- Parametrised successor to the team's 8-bit D register with set/clear.
- Register of WIDTH bits with async clear and sync preset.
- Eight-way mode select: hold, shift right, shift left, parallel load, rotate right, rotate left, sync clear, reserved.
- Shift-progress counter with a DONE pulse after WIDTH shifts; serves as the serial/parallel converter in lab datapaths (UART-style framing, LED chasers).

---
 rtl/univ_shift_reg_if.sv | 77 +++++++
 rtl/univ_shift_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_if
//
// Purpose:
//   Bundles the control, data and status signals of the universal shift
//   register so that a lab datapath can hand one connection to the block
//   instead of eleven loose wires. Clock and clear stay outside the bundle
//   as plain ports on the register itself.
//
// Parameters:
//   WIDTH  register width in bits (2..32)
//   CW     width of the shift-progress counter, $clog2(WIDTH+1)
//
// Signals:
//   Setn   synchronous active-low preset (Q -> all ones)
//   EN     clock enable for MODE operations
//   MODE   3-bit operation select
//   D      parallel load data
//   SR     serial input entering the MSB on shift right
//   SL     serial input entering the LSB on shift left
//   Q      register contents
//   SO_R   serial output on the right, Q[0]
//   SO_L   serial output on the left, Q[WIDTH-1]
//   CNT    shifts since the last load/set/clear, saturating at WIDTH
//   DONE   one-cycle pulse after the WIDTH-th shift
//
// Modports:
//   master  the datapath that drives controls and reads status
//   slave   the shift register itself
// ---------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             Setn;
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SR;
    logic             SL;
    logic [WIDTH-1:0] Q;
    logic             SO_R;
    logic             SO_L;
    logic [CW-1:0]    CNT;
    logic             DONE;

    modport master (
        output Setn,
        output EN,
        output MODE,
        output D,
        output SR,
        output SL,
        input  Q,
        input  SO_R,
        input  SO_L,
        input  CNT,
        input  DONE
    );

    modport slave (
        input  Setn,
        input  EN,
        input  MODE,
        input  D,
        input  SR,
        input  SL,
        output Q,
        output SO_R,
        output SO_L,
        output CNT,
        output DONE
    );

endinterface

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Purpose:
//   Parametrised universal shift register, the successor of the old 8-bit
//   D register with set/clear. Besides hold/load/clear it shifts and rotates
//   in both directions and keeps a saturating count of shifts so that a
//   datapath knows when a full word has been serialised or deserialised
//   (UART-style framing, LED chasers).
//
// Parameters:
//   WIDTH  register width in bits, 2..32
//
// Ports:
//   CLK    rising-edge clock
//   Clrn   asynchronous active-low clear of Q, CNT and DONE
//   bus    univ_shift_reg_if slave modport:
//            in : Setn, EN, MODE, D, SR, SL
//            out: Q, SO_R, SO_L, CNT, DONE
//
// Operation priority at each rising edge: Setn low, then EN low, then MODE.
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              Clrn,
    univ_shift_reg_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] cnt_full = CW'(WIDTH);
    localparam logic [CW-1:0] cnt_last = CW'(WIDTH - 1);

    // Operation codes carried on MODE. The last code is unassigned and is
    // treated exactly like hold so that a stray value cannot corrupt Q.
    typedef enum logic [2:0] {
        MODE_HOLD     = 3'b000,
        MODE_SHR      = 3'b001,
        MODE_SHL      = 3'b010,
        MODE_LOAD     = 3'b011,
        MODE_ROR      = 3'b100,
        MODE_ROL      = 3'b101,
        MODE_CLEAR    = 3'b110,
        MODE_RESERVED = 3'b111
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             done_reg;
    logic             done_next;
    logic             shift_op;

    assign mode = mode_e'(bus.MODE);

    // Next-state logic for the data register. Preset beats the enable, and
    // the enable gates every MODE operation. Shifts and rotates in either
    // direction are flagged as a single "shift_op" because they all advance
    // the progress counter the same way.
    always_comb begin
        q_next   = q_reg;
        shift_op = 1'b0;

        if (!bus.Setn) begin
            q_next = '1;
        end else if (bus.EN) begin
            case (mode)
                MODE_SHR: begin
                    q_next   = {bus.SR, q_reg[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_SHL: begin
                    q_next   = {q_reg[WIDTH-2:0], bus.SL};
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_next = bus.D;
                end
                MODE_ROR: begin
                    q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_CLEAR: begin
                    q_next = '0;
                end
                MODE_HOLD, MODE_RESERVED: begin
                    q_next = q_reg;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    // Next-state logic for the progress counter and the DONE pulse. The
    // counter restarts on preset, load and sync clear, and saturates at
    // WIDTH. DONE is computed here from the old count so that the
    // registered pulse lands in the cycle right after the WIDTH-th shift
    // and never repeats while the count sits at WIDTH.
    always_comb begin
        cnt_next  = cnt_reg;
        done_next = 1'b0;

        if (!bus.Setn) begin
            cnt_next = '0;
        end else if (bus.EN) begin
            if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
                cnt_next = '0;
            end else if (shift_op && (cnt_reg < cnt_full)) begin
                cnt_next  = cnt_reg + CW'(1);
                done_next = (cnt_reg == cnt_last);
            end
        end
    end

    // State registers. Clrn acts immediately and overrides everything,
    // including a simultaneous preset, which also aborts any shift sequence
    // in progress without producing a DONE pulse.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            q_reg    <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    // Serial outputs come straight from Q so the bit about to leave on the
    // next shift is visible before the edge.
    assign bus.Q    = q_reg;
    assign bus.SO_R = q_reg[0];
    assign bus.SO_L = q_reg[WIDTH-1];
    assign bus.CNT  = cnt_reg;
    assign bus.DONE = done_reg;

endmodule
